instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Fetch stage of the NN processor. Holds the program counter and drives a synchronous-read instruction memory. Latches the fetched word into an instruction register and splits it into opcode, register and immediate fields. The opcode feeds `controlUnit`; the remaining fields feed the register file and datapath. `controlUnit.PCEn` and a downstream stall gate advancement, and the unit freezes itself after fetching HALT.

## Interface
- `PC_W`, default 8: instruction address width; the PC wraps modulo 2^PC_W.
- `INSTR_W`, default 32: instruction word width. The field layout below assumes 32.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `pc_en` in 1: PCEn from `controlUnit`.
- `stall` in 1: downstream hazard hold.
- `imem_addr` out PC_W: instruction memory read address.
- `imem_rdata` in INSTR_W: memory data, valid one cycle after the address.
- `opcode` out 4: `ir[31:28]`.
- `rs` out 4: `ir[27:24]`.
- `rt` out 4: `ir[23:20]`.
- `rd` out 4: `ir[19:16]`.
- `imm_ext` out 32: `ir[15:0]` sign-extended.
- `pc_out` out PC_W: address of the instruction currently in IR.
- `instr_valid` out 1: IR holds a live instruction.
- `illegal_op` out 1: `instr_valid` is high and the opcode is outside {0000, 0001, 1001, 0010, 0011, 0100, 1110, 1111, 1011}. Combinational.
- `halted` out 1: sticky; set after HALT is consumed, cleared only by reset.

## Operation
- `advance = pc_en & ~stall & (state == RUN | state == HALTING)`.
- `imem_addr = fetch_pc + (advance & state == RUN)`, computed combinationally. This makes `imem_rdata` always equal `mem[fetch_pc]` in RUN.
- States:
  - PRIME: entered on reset. No advance. Goes to RUN after 1 cycle.
  - RUN: on advance, `ir <= imem_rdata`, `ir_pc <= fetch_pc`, `fetch_pc <= fetch_pc + 1`, `instr_valid <= 1`. If the loaded opcode is 1011 (HALT), go to HALTING.
  - HALTING: `fetch_pc` and `imem_addr` are frozen. IR keeps HALT with `instr_valid = 1` until advance. On advance, IR becomes NOP (all zero), `instr_valid <= 0`, `halted <= 1`, and the state goes to HALTED.
  - HALTED: terminal. All outputs hold; only reset exits.
- No advance means IR, `pc_out` and `fetch_pc` all hold. The memory re-reads the same address, so `imem_rdata` stays stable.
- `fetch_pc` increments from 2^PC_W−1 to 0 silently; no flag is raised.
- Reset values:
  - `fetch_pc`, `imem_addr`, `pc_out` = 0.
  - IR = 0, so every field output is 0.
  - `instr_valid`, `halted`, `illegal_op` = 0.
  - State = PRIME.
- Reset mid-run or mid-HALTING: all of the above take effect on the next edge, and any in-flight fetch is discarded.

## Timing
- Reset is released at edge E0. PRIME occupies the cycle after E0. The earliest advance is the cycle after E1, so the first instruction is in IR after E2.
- Throughput is 1 instruction per cycle while `pc_en & ~stall`.
- Field outputs are registered (IR) with combinational slicing only. Latency from `imem_addr` to IR is 1 memory cycle plus 1 load.
- Stall and `pc_en` are sampled the same cycle, with no skid.
- A HALT word reaches IR, and `controlUnit` sees opcode 1011 in that cycle. `halted` rises one advance later.

## Structure
- Shared package `nn_isa_pkg`:
  - opcode constants: OP_NOP, OP_ADD, OP_ADDI, OP_MUL, OP_SINN, OP_MAC, OP_LD, OP_ST, OP_HALT;
  - field bit positions;
  - NOP_WORD;
  - fetch state enum.
- Sub-module `instr_field_decode`: combinational slicing, sign extension and the legal-opcode check. It is shared with any later decode stage.

## Test plan
- Reset then free run, memory `mem[0..2]` = {0x1123_0000, 0x9450_FFFF, 0x0000_0000} -> after E2, IR shows opcode 1, rs 1, rt 2, rd 3. The next cycle shows opcode 9 and `imm_ext` = 0xFFFF_FFFF, with `pc_out` at 0, 1, 2 on consecutive cycles.
- `stall` high for 3 cycles while IR holds `pc_out` = 1 -> IR, `pc_out` and `imem_addr` hold. The cycle after release loads `mem[2]`, with no skipped or duplicated instruction.
- `mem[3]` = 0xB000_0000 (HALT) -> opcode 1011 with `instr_valid` = 1 for one cycle. Next: `instr_valid` = 0, opcode 0, `halted` = 1, `imem_addr` frozen at 4 for 10 or more cycles.
- HALT in IR with `stall` held for 2 cycles -> `halted` stays 0 until `stall` drops, then rises.
- PC_W = 3 running from address 6 -> `pc_out` 6, 7, 0, 1. Opcode 0x5 at address 7 -> `illegal_op` = 1 for exactly that cycle.
- Reset asserted for 1 cycle while in HALTING -> all outputs return to reset values, then the fetch restarts at address 0.

Source files
------------

// File: rtl/nn_isa_pkg.sv
// ============================================================================
// Module   : nn_isa_pkg
// Purpose  : NN processor ISA constants, field layout and fetch state encoding
// Revision : 1.0
// ============================================================================
`default_nettype none

package nn_isa_pkg;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_ADDI = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_SINN = 4'b0011;
    localparam logic [3:0] OP_MAC  = 4'b0100;
    localparam logic [3:0] OP_LD   = 4'b1110;
    localparam logic [3:0] OP_ST   = 4'b1111;
    localparam logic [3:0] OP_HALT = 4'b1011;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 28;
    localparam int RS_MSB     = 27;
    localparam int RS_LSB     = 24;
    localparam int RT_MSB     = 23;
    localparam int RT_LSB     = 20;
    localparam int RD_MSB     = 19;
    localparam int RD_LSB     = 16;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_PRIME   = 2'd0,
        ST_RUN     = 2'd1,
        ST_HALTING = 2'd2,
        ST_HALTED  = 2'd3
    } fetch_state_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        case (op)
            OP_NOP, OP_ADD, OP_ADDI, OP_MUL, OP_SINN,
            OP_MAC, OP_LD, OP_ST, OP_HALT: is_legal_op = 1'b1;
            default:                       is_legal_op = 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/instr_field_decode.sv
// ============================================================================
// Module   : instr_field_decode
// Purpose  : Slices an instruction word into fields and flags illegal opcodes
// Revision : 1.0
// ============================================================================
`default_nettype none

module instr_field_decode
    import nn_isa_pkg::*;
#(
    parameter int INSTR_W = 32
) (
    input  logic [INSTR_W-1:0] ir,
    input  logic               valid,
    output logic [3:0]         opcode,
    output logic [3:0]         rs,
    output logic [3:0]         rt,
    output logic [3:0]         rd,
    output logic [31:0]        imm_ext,
    output logic               illegal_op
);

    assign opcode     = ir[OPCODE_MSB:OPCODE_LSB];
    assign rs         = ir[RS_MSB:RS_LSB];
    assign rt         = ir[RT_MSB:RT_LSB];
    assign rd         = ir[RD_MSB:RD_LSB];
    assign imm_ext    = {{16{ir[IMM_MSB]}}, ir[IMM_MSB:IMM_LSB]};
    assign illegal_op = valid & ~is_legal_op(ir[OPCODE_MSB:OPCODE_LSB]);

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : PC, synchronous-read imem addressing, IR and HALT freeze
// Revision : 1.0
// ============================================================================
`default_nettype none

module instr_fetch_unit
    import nn_isa_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pc_en,
    input  logic               stall,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [3:0]         opcode,
    output logic [3:0]         rs,
    output logic [3:0]         rt,
    output logic [3:0]         rd,
    output logic [31:0]        imm_ext,
    output logic [PC_W-1:0]    pc_out,
    output logic               instr_valid,
    output logic               illegal_op,
    output logic               halted
);

    fetch_state_t        r_state;
    fetch_state_t        w_state_next;
    logic [PC_W-1:0]     r_fetch_pc;
    logic [PC_W-1:0]     r_ir_pc;
    logic [INSTR_W-1:0]  r_ir;
    logic                r_valid;
    logic                r_halted;
    logic                w_advance;
    logic                w_run_adv;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_PRIME;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_PRIME:   w_state_next = ST_RUN;
            ST_RUN:     if (w_advance && imem_rdata[OPCODE_MSB:OPCODE_LSB] == OP_HALT)
                            w_state_next = ST_HALTING;
            ST_HALTING: if (w_advance) w_state_next = ST_HALTED;
            default:    w_state_next = ST_HALTED;
        endcase
    end

    // Look-ahead addressing keeps imem_rdata equal to mem[fetch_pc] in RUN.
    always_comb begin
        w_advance = pc_en & ~stall & (r_state == ST_RUN || r_state == ST_HALTING);
        w_run_adv = w_advance & (r_state == ST_RUN);
        imem_addr = r_fetch_pc + PC_W'(w_run_adv);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc <= '0;
            r_ir_pc    <= '0;
            r_ir       <= '0;
            r_valid    <= 1'b0;
            r_halted   <= 1'b0;
        end else if (w_run_adv) begin
            r_ir       <= imem_rdata;
            r_ir_pc    <= r_fetch_pc;
            r_fetch_pc <= r_fetch_pc + PC_W'(1);
            r_valid    <= 1'b1;
        end else if (w_advance) begin
            // HALT consumed: replace it with a NOP and freeze for good.
            r_ir       <= INSTR_W'(NOP_WORD);
            r_valid    <= 1'b0;
            r_halted   <= 1'b1;
        end
    end

    instr_field_decode #(
        .INSTR_W (INSTR_W)
    ) u_decode (
        .ir         (r_ir),
        .valid      (r_valid),
        .opcode     (opcode),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .imm_ext    (imm_ext),
        .illegal_op (illegal_op)
    );

    assign pc_out      = r_ir_pc;
    assign instr_valid = r_valid;
    assign halted      = r_halted;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// Module   : tb_instr_fetch_unit
// Purpose  : Self-checking bench for instr_fetch_unit (PC_W=8 and PC_W=3)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default widths
    logic        reset_a, pc_en_a, stall_a;
    logic [7:0]  imem_addr_a, pc_out_a;
    logic [31:0] imem_rdata_a, imm_ext_a;
    logic [3:0]  opcode_a, rs_a, rt_a, rd_a;
    logic        instr_valid_a, illegal_op_a, halted_a;
    logic [31:0] mem_a [256];

    // Instance B: 3-bit PC for wrap checks
    logic        reset_b, pc_en_b, stall_b;
    logic [2:0]  imem_addr_b, pc_out_b;
    logic [31:0] imem_rdata_b, imm_ext_b;
    logic [3:0]  opcode_b, rs_b, rt_b, rd_b;
    logic        instr_valid_b, illegal_op_b, halted_b;
    logic [31:0] mem_b [8];

    always @(posedge clk) imem_rdata_a <= mem_a[imem_addr_a];
    always @(posedge clk) imem_rdata_b <= mem_b[imem_addr_b];

    instr_fetch_unit #(.PC_W(8), .INSTR_W(32)) dut_a (
        .clk(clk), .reset(reset_a), .pc_en(pc_en_a), .stall(stall_a),
        .imem_addr(imem_addr_a), .imem_rdata(imem_rdata_a),
        .opcode(opcode_a), .rs(rs_a), .rt(rt_a), .rd(rd_a), .imm_ext(imm_ext_a),
        .pc_out(pc_out_a), .instr_valid(instr_valid_a),
        .illegal_op(illegal_op_a), .halted(halted_a)
    );

    instr_fetch_unit #(.PC_W(3), .INSTR_W(32)) dut_b (
        .clk(clk), .reset(reset_b), .pc_en(pc_en_b), .stall(stall_b),
        .imem_addr(imem_addr_b), .imem_rdata(imem_rdata_b),
        .opcode(opcode_b), .rs(rs_b), .rt(rt_b), .rd(rd_b), .imm_ext(imm_ext_b),
        .pc_out(pc_out_b), .instr_valid(instr_valid_b),
        .illegal_op(illegal_op_b), .halted(halted_b)
    );

    typedef struct {
        logic        rst, en, st;
        logic        valid, chk_pc;
        logic [7:0]  pc;
        logic [31:0] word;
        logic        halted;
        logic [7:0]  addr;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [31:0] W0   = 32'h1123_0000;
    localparam logic [31:0] W1   = 32'h9450_FFFF;
    localparam logic [31:0] W2   = 32'h0000_0000;
    localparam logic [31:0] HALT = 32'hB000_0000;

    function automatic vec_t mk(input logic rst, en, st, valid, chk_pc,
                                input logic [7:0] pc, input logic [31:0] word,
                                input logic hlt, input logic [7:0] addr);
        vec_t v;
        v.rst = rst; v.en = en; v.st = st; v.valid = valid; v.chk_pc = chk_pc;
        v.pc = pc; v.word = word; v.halted = hlt; v.addr = addr;
        return v;
    endfunction

    function automatic logic legal(input logic [3:0] op);
        return op inside {4'h0, 4'h1, 4'h9, 4'h2, 4'h3, 4'h4, 4'hE, 4'hF, 4'hB};
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_a(input vec_t e, input int idx);
        logic [31:0] w;
        w = e.word;
        cmp($sformatf("row%0d valid", idx),   {31'd0, instr_valid_a}, {31'd0, e.valid});
        if (e.chk_pc) cmp($sformatf("row%0d pc_out", idx), {24'd0, pc_out_a}, {24'd0, e.pc});
        cmp($sformatf("row%0d opcode", idx),  {28'd0, opcode_a}, {28'd0, w[31:28]});
        cmp($sformatf("row%0d rs", idx),      {28'd0, rs_a},     {28'd0, w[27:24]});
        cmp($sformatf("row%0d rt", idx),      {28'd0, rt_a},     {28'd0, w[23:20]});
        cmp($sformatf("row%0d rd", idx),      {28'd0, rd_a},     {28'd0, w[19:16]});
        cmp($sformatf("row%0d imm_ext", idx), imm_ext_a,         {{16{w[15]}}, w[15:0]});
        cmp($sformatf("row%0d illegal", idx), {31'd0, illegal_op_a},
            {31'd0, e.valid & ~legal(w[31:28])});
        cmp($sformatf("row%0d halted", idx),  {31'd0, halted_a}, {31'd0, e.halted});
        cmp($sformatf("row%0d imem_addr", idx), {24'd0, imem_addr_a}, {24'd0, e.addr});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t e;
        for (int i = 0; i < 256; i++) mem_a[i] = 32'h0;
        mem_a[0] = W0; mem_a[1] = W1; mem_a[2] = W2; mem_a[3] = HALT;
        mem_a[4] = 32'h2AB0_1234; mem_a[5] = 32'h4120_8000;
        for (int i = 0; i < 8; i++) mem_b[i] = 32'h1000_0000 | i;
        mem_b[7] = 32'h5000_0000;

        reset_a = 1'b1; pc_en_a = 1'b0; stall_a = 1'b0;
        reset_b = 1'b1; pc_en_b = 1'b1; stall_b = 1'b0;

        // Free run, 3-cycle stall at pc 1, HALT at address 3
        vecs.push_back(mk(1,1,0, 0,1,0,0,    0,0));
        vecs.push_back(mk(0,1,0, 0,1,0,0,    0,1));
        vecs.push_back(mk(0,1,0, 1,1,0,W0,   0,2));
        vecs.push_back(mk(0,1,0, 1,1,1,W1,   0,3));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0,1,1, 1,1,1,W1, 0,2));
        vecs.push_back(mk(0,1,0, 1,1,2,W2,   0,4));
        vecs.push_back(mk(0,1,0, 1,1,3,HALT, 0,4));
        vecs.push_back(mk(0,1,0, 0,0,0,0,    1,4));
        for (int i = 0; i < 11; i++)
            vecs.push_back(mk(0, i[0], i[1], 0,0,0,0, 1,4));
        // HALT held by pc_en low and a 2-cycle stall
        vecs.push_back(mk(1,1,0, 0,1,0,0,    0,0));
        vecs.push_back(mk(0,1,0, 0,1,0,0,    0,1));
        vecs.push_back(mk(0,1,0, 1,1,0,W0,   0,2));
        vecs.push_back(mk(0,1,0, 1,1,1,W1,   0,3));
        vecs.push_back(mk(0,1,0, 1,1,2,W2,   0,4));
        vecs.push_back(mk(0,1,0, 1,1,3,HALT, 0,4));
        vecs.push_back(mk(0,0,0, 1,1,3,HALT, 0,4));
        vecs.push_back(mk(0,1,1, 1,1,3,HALT, 0,4));
        vecs.push_back(mk(0,1,1, 1,1,3,HALT, 0,4));
        vecs.push_back(mk(0,1,0, 0,0,0,0,    1,4));
        // pc_en low in RUN, then reset while HALTING and restart
        vecs.push_back(mk(1,1,0, 0,1,0,0,    0,0));
        vecs.push_back(mk(0,1,0, 0,1,0,0,    0,1));
        vecs.push_back(mk(0,0,0, 0,1,0,0,    0,0));
        vecs.push_back(mk(0,1,0, 1,1,0,W0,   0,2));
        vecs.push_back(mk(0,1,0, 1,1,1,W1,   0,3));
        vecs.push_back(mk(0,1,0, 1,1,2,W2,   0,4));
        vecs.push_back(mk(0,1,0, 1,1,3,HALT, 0,4));
        vecs.push_back(mk(1,1,0, 0,1,0,0,    0,0));
        vecs.push_back(mk(0,1,0, 0,1,0,0,    0,1));
        vecs.push_back(mk(0,1,0, 1,1,0,W0,   0,2));
        vecs.push_back(mk(0,1,0, 1,1,1,W1,   0,3));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset_a = vecs[i].rst; pc_en_a = vecs[i].en; stall_a = vecs[i].st;
            sb.push_back(vecs[i]);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL scoreboard: queue empty at row %0d", i);
            end else begin
                e = sb.pop_front();
                check_a(e, i);
            end
        end

        // Wrap with 3-bit PC; illegal opcode 0x5 sits at address 7
        cmp("b_reset_addr",    {29'd0, imem_addr_b}, 32'd0);
        cmp("b_reset_illegal", {31'd0, illegal_op_b}, 32'd0);
        @(negedge clk);
        reset_b = 1'b0;
        @(posedge clk);
        #1;
        cmp("b_e1_valid", {31'd0, instr_valid_b}, 32'd0);
        cmp("b_e1_addr",  {29'd0, imem_addr_b}, 32'd1);
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            cmp($sformatf("b%0d pc_out", k),  {29'd0, pc_out_b}, k % 8);
            cmp($sformatf("b%0d valid", k),   {31'd0, instr_valid_b}, 32'd1);
            cmp($sformatf("b%0d opcode", k),  {28'd0, opcode_b}, (k % 8 == 7) ? 32'd5 : 32'd1);
            cmp($sformatf("b%0d illegal", k), {31'd0, illegal_op_b},
                (k % 8 == 7) ? 32'd1 : 32'd0);
            cmp($sformatf("b%0d imem_addr", k), {29'd0, imem_addr_b}, (k + 2) % 8);
            cmp($sformatf("b%0d halted", k),  {31'd0, halted_b}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
